weight_mem_arbiter: RTL

- Shares the single-port 16x32 weight memory of the head between NREQ requesters (e.g. port 0 = head execute unit, port 1 = host/DMA weight loader).
- Round-robin arbitration with a per-beat valid/ready handshake.
- Optional lock so a requester keeps the memory for a full 4x4 matrix burst.
- Sits between the requesters and the weight memory; the memory has 1-cycle registered read latency.

---
 rtl/head_pkg.sv | 29 ++
 rtl/rr_pick.sv | 33 +++
 rtl/weight_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/head_pkg.sv
// Shared definitions for the head datapath: weight memory geometry,
// arbiter state encoding, response tag bundle and a round-robin helper.
package head_pkg;

    localparam int WMEM_AW    = 4;
    localparam int WMEM_DW    = 32;
    localparam int WMEM_DEPTH = 16;

    // Widest requester id any arbiter in the head needs (up to 4 ports).
    localparam int MAX_ID_W = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Requester tag travelling alongside a beat towards its response.
    typedef struct packed {
        logic                valid;
        logic                is_read;
        logic [MAX_ID_W-1:0] id;
    } rsp_tag_t;

    // Next round-robin start position after requester i was served.
    function automatic int rr_next(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority select.
// Ports: req (request vector), ptr (search start) -> gnt (one-hot),
//        idx (winner index), any (some request present).
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Scan from ptr upward, wrapping at N; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_mem_arbiter.sv
// Round-robin arbiter sharing the single-port weight memory between NREQ
// requesters, with optional lock for multi-beat bursts.
// Ports: clk/rst; per-requester req_valid/ready/we/lock/addr/wdata;
//        rsp_valid (per requester) + shared rsp_rdata; mem_* to the memory.
module weight_mem_arbiter
    import head_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = WMEM_AW,
    parameter int DW   = WMEM_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e    state;
    logic [IW-1:0] rr;
    logic [IW-1:0] owner;

    logic [NREQ-1:0] elig;
    logic [IW-1:0]   pick_ptr;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   idx;
    logic            any;

    logic            accept;
    logic            b_we;
    logic            b_lock;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_wdata;
    logic [IW-1:0]   nxt;

    logic            en_q;
    logic            we_q;
    rsp_tag_t        s1;
    rsp_tag_t        s2;

    // While locked only the owner is eligible; searching from the owner
    // keeps a single picker for both states.
    always_comb begin
        elig     = req_valid;
        pick_ptr = rr;
        if (state == LOCKED) begin
            elig     = req_valid & (NREQ'(1) << owner);
            pick_ptr = owner;
        end
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (elig),
        .ptr (pick_ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    assign req_ready = rst ? '0 : gnt;
    assign accept    = any & ~rst;

    assign b_we    = req_we[idx];
    assign b_lock  = req_lock[idx];
    assign b_addr  = req_addr[idx*AW +: AW];
    assign b_wdata = req_wdata[idx*DW +: DW];

    assign nxt = IW'(rr_next(int'(idx), NREQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            rr    <= '0;
            owner <= '0;
        end else if (accept) begin
            if (b_lock) begin
                state <= LOCKED;
                owner <= idx;
            end else begin
                state <= ARB;
                rr    <= nxt;
            end
        end
    end

    // Memory command stage plus the two-deep response tag shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1        <= '0;
            s2        <= '0;
        end else begin
            en_q       <= accept;
            we_q       <= accept & b_we;
            s1.valid   <= accept;
            s1.is_read <= accept & ~b_we;
            if (accept) begin
                mem_addr  <= b_addr;
                mem_wdata <= b_wdata;
                s1.id     <= MAX_ID_W'(idx);
            end
            s2 <= s1;
        end
    end

    // Gating with rst keeps a beat registered at the reset edge from
    // reaching the memory and suppresses any response during reset.
    assign mem_en = en_q & ~rst;
    assign mem_we = we_q & ~rst;

    always_comb begin
        rsp_valid = '0;
        if (s2.valid && s2.is_read && !rst) begin
            rsp_valid = NREQ'(1) << s2.id;
        end
    end

    assign rsp_rdata = mem_rdata;

endmodule
